// File: rtl/exmem_arbiter_if.sv
// Requester-side bus bundle between one requester and exmem_arbiter.
// master = requester, slave = arbiter.
interface exmem_arbiter_if #(
    parameter int unsigned AW = 32
);
    logic          stb;
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] addr;
    logic [31:0]   dat_i;
    logic          stall;
    logic          ack;
    logic [31:0]   dat_o;

    modport master (
        output stb, we, sel, addr, dat_i,
        input  stall, ack, dat_o
    );

    modport slave (
        input  stb, we, sel, addr, dat_i,
        output stall, ack, dat_o
    );
endinterface

// File: rtl/exmem_arbiter.sv
// Two-requester arbiter onto one fixed-latency pipelined memory port, with tag FIFO response routing.
// Optional: define EXMEM_ARB_FIXED_PRIO_EN to make M0 win every tie (default: round-robin).
module exmem_arbiter #(
    parameter int unsigned OUTSTANDING = 16,
    parameter int unsigned AW          = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    exmem_arbiter_if.slave m0,
    exmem_arbiter_if.slave m1,
    output logic           mem_stb,
    output logic           mem_we,
    output logic [3:0]     mem_sel,
    output logic [AW-1:0]  mem_addr,
    output logic [31:0]    mem_dat_i,
    input  logic           mem_ack,
    input  logic [31:0]    mem_dat_o,
    output logic           err_orphan
);
    localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(OUTSTANDING + 1);

    logic [OUTSTANDING-1:0] tag_q, tag_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   last_gnt_q, last_gnt_d;
    logic                   err_orphan_q, err_orphan_d;

    logic full;
    logic gnt0;
    logic gnt1;
    logic push;
    logic pop;
    logic head;

    // Grant: full is taken from the registered count, before any same-cycle pop
    always_comb begin
        full = (count_q == CW'(OUTSTANDING));
`ifdef EXMEM_ARB_FIXED_PRIO_EN
        gnt0 = m0.stb & ~full;
`else
        gnt0 = m0.stb & ~full & (~m1.stb | last_gnt_q);
`endif
        gnt1 = m1.stb & ~full & ~gnt0;
    end

    assign m0.stall = m0.stb & ~gnt0;
    assign m1.stall = m1.stb & ~gnt1;

    // Request mux to memory, zeroed when idle
    always_comb begin
        mem_stb   = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_sel   = '0;
        mem_addr  = '0;
        mem_dat_i = '0;
        if (gnt0) begin
            mem_we    = m0.we;
            mem_sel   = m0.sel;
            mem_addr  = m0.addr;
            mem_dat_i = m0.dat_i;
        end else if (gnt1) begin
            mem_we    = m1.we;
            mem_sel   = m1.sel;
            mem_addr  = m1.addr;
            mem_dat_i = m1.dat_i;
        end
    end

    // Response routing: head tag names the requester of the oldest in-flight request
    assign push     = mem_stb;
    assign pop      = mem_ack & (count_q != '0);
    assign head     = tag_q[rd_ptr_q];
    assign m0.ack   = pop & ~head;
    assign m1.ack   = pop & head;
    assign m0.dat_o = mem_dat_o;
    assign m1.dat_o = mem_dat_o;

    always_comb begin
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_gnt_d   = last_gnt_q;
        err_orphan_d = err_orphan_q | (mem_ack & (count_q == '0));
        if (push) begin
            tag_d[wr_ptr_q] = gnt1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_gnt_q   <= 1'b1;
            err_orphan_q <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_gnt_q   <= last_gnt_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign err_orphan = err_orphan_q;
endmodule

// File: tb/tb_exmem_arbiter.sv
// Directed bench for exmem_arbiter (OUTSTANDING=4) with an 11-cycle memory model and an ack scoreboard.
module tb_exmem_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned LAT = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exmem_arbiter_if #(.AW(AW)) m0_if ();
    exmem_arbiter_if #(.AW(AW)) m1_if ();

    logic          mem_stb;
    logic          mem_we;
    logic [3:0]    mem_sel;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_dat_i;
    logic          mem_ack;
    logic          mdl_ack;
    logic          orph;
    logic [31:0]   mem_dat_o;
    logic          err_orphan;

    exmem_arbiter #(.OUTSTANDING(4), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0         (m0_if),
        .m1         (m1_if),
        .mem_stb    (mem_stb),
        .mem_we     (mem_we),
        .mem_sel    (mem_sel),
        .mem_addr   (mem_addr),
        .mem_dat_i  (mem_dat_i),
        .mem_ack    (mem_ack),
        .mem_dat_o  (mem_dat_o),
        .err_orphan (err_orphan)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Fixed-latency memory: a request seen in cycle c acks in cycle c+LAT
    int unsigned cyc;
    logic [63:0] slot_v;
    logic [31:0] slot_d [64];
    logic [5:0]  sidx_w, sidx_r;
    assign sidx_w  = 6'(cyc + LAT);
    assign sidx_r  = 6'(cyc + 1);
    assign mem_ack = mdl_ack | orph;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc       <= 0;
            slot_v    <= '0;
            mdl_ack   <= 1'b0;
            mem_dat_o <= '0;
        end else begin
            cyc <= cyc + 1;
            if (mem_stb) begin
                slot_v[sidx_w] <= 1'b1;
                slot_d[sidx_w] <= mdata(mem_addr);
            end
            mdl_ack        <= slot_v[sidx_r];
            mem_dat_o      <= slot_d[sidx_r];
            slot_v[sidx_r] <= 1'b0;
        end
    end

    typedef struct {
        int          id;
        logic [31:0] dat;
        int unsigned cyc;
    } exp_t;
    exp_t sb[$];

    int unsigned tot  = 0;
    int unsigned pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act === exp) pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    endtask

    // Monitor: every ack pops one expected response
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (m0_if.ack || m1_if.ack)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'b0, m1_if.ack, m0_if.ack}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("ack_id", {30'b0, m1_if.ack, m0_if.ack}, (e.id == 0) ? 32'h1 : 32'h2);
                chk("ack_data", (e.id == 0) ? m0_if.dat_o : m1_if.dat_o, e.dat);
                chk("ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input int id, input logic stb, input logic we, input logic [31:0] a);
        if (id == 0) begin
            m0_if.stb = stb; m0_if.we = we; m0_if.sel = 4'hF; m0_if.addr = a; m0_if.dat_i = ~a;
        end else begin
            m1_if.stb = stb; m1_if.we = we; m1_if.sel = 4'h3; m1_if.addr = a; m1_if.dat_i = ~a;
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] a);
        exp_t e;
        e.id  = id;
        e.dat = mdata(a);
        e.cyc = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk(nm, 32'(sb.size()), 32'h0);
        @(negedge clk);
    endtask

    int   n0, n1, g, guard, got, k;
    logic stl;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        orph = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_stb", 32'(mem_stb), 32'h0);
        chk("rst_err", 32'(err_orphan), 32'h0);
        chk("rst_acks", {30'b0, m1_if.ack, m0_if.ack}, 32'h0);
        rst_n = 1'b1;

`ifndef EXMEM_ARB_FIXED_PRIO_EN
        // Contention: 4 requests each, expected M0,M1,M0,M1,...
        n0 = 0; n1 = 0; g = 0; guard = 0;
        nxt;
        drive(0, 1'b1, 1'b0, 32'h100);
        drive(1, 1'b1, 1'b1, 32'h200);
        while (g < 8 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (mem_stb) begin
                got = (m0_if.stb && !m0_if.stall) ? 0 : 1;
                chk("rr_grant", 32'(got), 32'(g % 2));
                chk("rr_addr", mem_addr, (g % 2 == 0) ? 32'h100 + 32'(n0) : 32'h200 + 32'(n1));
                chk("rr_we", 32'(mem_we), 32'(g % 2));
                push_exp(g % 2, (g % 2 == 0) ? 32'h100 + 32'(n0) : 32'h200 + 32'(n1));
                g++;
                nxt;
                if (got == 0) begin
                    n0++;
                    drive(0, n0 < 4, 1'b0, 32'h100 + 32'(n0));
                end else begin
                    n1++;
                    drive(1, n1 < 4, 1'b1, 32'h200 + 32'(n1));
                end
            end else begin
                chk("rr_full_stall", {30'b0, m1_if.stall, m0_if.stall}, {30'b0, m1_if.stb, m0_if.stb});
                nxt;
            end
        end
        chk("rr_grants", 32'(g), 32'd8);
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0);
        drain("rr_drain");
`endif

        // Single M0 read
        nxt;
        drive(0, 1'b1, 1'b0, 32'h10);
        @(negedge clk);
        chk("t1_stall", 32'(m0_if.stall), 32'h0);
        chk("t1_mem_stb", 32'(mem_stb), 32'h1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_sel", 32'(mem_sel), 32'hF);
        push_exp(0, 32'h10);
        nxt;
        drive(0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("t1_stb_pulse", 32'(mem_stb), 32'h0);
        drain("t1_drain");

        // Fill: accepts at offsets 0-3, then stalled until the cycle after the first ack
        k = 0;
        nxt;
        drive(0, 1'b1, 1'b0, 32'h300);
        for (int off = 0; off < 14; off++) begin
            @(negedge clk);
            stl = m0_if.stall;
            chk("fill_stall", 32'(stl), (off < 4 || off >= 12) ? 32'h0 : 32'h1);
            if (!stl) push_exp(0, 32'h300 + 32'(k));
            nxt;
            if (!stl) k++;
            drive(0, k < 6, 1'b0, 32'h300 + 32'(k));
        end
        drive(0, 1'b0, 1'b0, 32'h0);
        drain("fill_drain");

        // Orphan ack with empty FIFO
        nxt;
        orph = 1'b1;
        @(negedge clk);
        chk("orph_acks", {30'b0, m1_if.ack, m0_if.ack}, 32'h0);
        chk("orph_err_early", 32'(err_orphan), 32'h0);
        nxt;
        orph = 1'b0;
        @(negedge clk);
        chk("orph_err_set", 32'(err_orphan), 32'h1);
        repeat (5) @(negedge clk);
        chk("orph_err_sticky", 32'(err_orphan), 32'h1);

        // Reset with three requests in flight
        nxt;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 1'b0, 32'h500 + 32'(i));
            @(negedge clk);
            chk("t5_issue", 32'(m0_if.stall), 32'h0);
            push_exp(0, 32'h500 + 32'(i));
            nxt;
        end
        drive(0, 1'b0, 1'b0, 32'h0);
        nxt;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t5_rst_stb", 32'(mem_stb), 32'h0);
        chk("t5_rst_err", 32'(err_orphan), 32'h0);
        nxt;
        nxt;
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h600);
        drive(1, 1'b1, 1'b0, 32'h700);
        @(negedge clk);
        chk("t5_first_gnt", {30'b0, m1_if.stall, m0_if.stall}, 32'h2);
        push_exp(0, 32'h600);
        nxt;
        drive(0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("t5_m1_gnt", 32'(m1_if.stall), 32'h0);
        push_exp(1, 32'h700);
        nxt;
        drive(1, 1'b0, 1'b0, 32'h0);
        drain("t5_drain");
        repeat (15) @(negedge clk);
        chk("t5_no_orphan", 32'(err_orphan), 32'h0);

`ifdef EXMEM_ARB_FIXED_PRIO_EN
        // Fixed priority: M0 takes every grant while M1 waits
        n0 = 0; guard = 0;
        nxt;
        drive(0, 1'b1, 1'b0, 32'h800);
        drive(1, 1'b1, 1'b1, 32'h900);
        while (n0 < 6 && guard < 100) begin
            @(negedge clk);
            guard++;
            chk("fp_m1_stall", 32'(m1_if.stall), 32'h1);
            stl = m0_if.stall;
            if (!stl) push_exp(0, 32'h800 + 32'(n0));
            nxt;
            if (!stl) n0++;
            drive(0, n0 < 6, 1'b0, 32'h800 + 32'(n0));
        end
        chk("fp_grants", 32'(n0), 32'd6);
        drive(1, 1'b0, 1'b0, 32'h0);
        drain("fp_drain");
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end
endmodule
